// File: rtl/stream_source_gen_if.sv
// Ready/valid byte-stream link between a stream source and its sink.
//   valid : source has a word on data
//   data  : payload
//   ready : sink accepts the word this cycle
// master modport is the producing end, slave modport the consuming end.
interface stream_source_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_source_gen.sv
// Ready/valid burst transmitter for test harnesses. A start command emits a
// burst of cmd_len words, either incrementing from cmd_seed or following a
// Galois LFSR seeded by cmd_seed, honouring backpressure. A running modulo
// byte sum of accepted words lets a bench cross-check the receiving side.
//
// Ports
//   clk         clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   start       one-cycle command strobe, only looked at in IDLE
//   cmd_len     words in burst, captured on start
//   cmd_seed    first word / LFSR seed, captured on start
//   cmd_lfsr    0 = incrementing pattern, 1 = LFSR pattern
//   stream_out  master end of the ready/valid link
//   busy        high from accepted start until back in IDLE
//   done        one-cycle pulse after the last word is accepted
//   sent_count  words accepted in current/last burst
//   sum         modulo-2^DATA_WIDTH sum of accepted words in current/last burst
//
// state | meaning
// IDLE  | waiting for start
// SEND  | word presented with valid high, waiting for ready
// GAP   | idle spacing after an accepted word, valid low
// DONE  | burst finished, done pulses for this one cycle
module stream_source_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0]  cmd_seed,
    input  logic                   cmd_lfsr,
    stream_source_gen_if.master    stream_out,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_WIDTH-1:0]   sent_count,
    output logic [DATA_WIDTH-1:0]  sum
);

    // 0xB8 gives a maximal-length sequence for 8-bit words.
    localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(8'hB8);
    localparam bit                    HAS_GAP   = (GAP_CYCLES > 0);
    localparam int                    GAP_W     = $clog2(GAP_CYCLES + 2);
    localparam logic [GAP_W-1:0]      GAP_LOAD  = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  data_next;
    logic [DATA_WIDTH-1:0]  seed_eff;
    logic [LEN_WIDTH-1:0]   remain_q;
    logic                   lfsr_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   start_ok;
    logic                   xfer;
    logic                   last_word;

    assign start_ok  = (state_q == S_IDLE) && start;
    assign xfer      = (state_q == S_SEND) && stream_out.ready;
    // remain_q counts down, so a full-range cmd_len never wraps a counter.
    assign last_word = (remain_q == LEN_WIDTH'(1));

    // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
    assign seed_eff  = (cmd_lfsr && (cmd_seed == '0)) ? DATA_WIDTH'(1) : cmd_seed;

    always_comb begin
        data_next = data_q + DATA_WIDTH'(1);
        if (lfsr_q) begin
            data_next = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (cmd_len == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else if (HAS_GAP) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // valid comes only from the registered state, never from ready.
    always_comb begin
        stream_out.valid = (state_q == S_SEND);
        busy             = (state_q != S_IDLE);
        done             = (state_q == S_DONE);
    end

    assign stream_out.data = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            remain_q   <= '0;
            lfsr_q     <= 1'b0;
            gap_q      <= '0;
            sent_count <= '0;
            sum        <= '0;
        end else begin
            if (start_ok) begin
                data_q     <= seed_eff;
                remain_q   <= cmd_len;
                lfsr_q     <= cmd_lfsr;
                sent_count <= '0;
                sum        <= '0;
            end else if (xfer) begin
                data_q     <= data_next;
                remain_q   <= remain_q - LEN_WIDTH'(1);
                sent_count <= sent_count + LEN_WIDTH'(1);
                sum        <= sum + data_q;
                gap_q      <= GAP_LOAD;
            end else if ((state_q == S_GAP) && (gap_q != '0)) begin
                gap_q      <= gap_q - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_source_gen.sv
module tb_stream_source_gen;
    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          start_g = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic          cmd_lfsr = 1'b0;
    logic          busy, done, busy_g, done_g;
    logic [LW-1:0] sent_count, sent_count_g;
    logic [DW-1:0] sum, sum_g;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_sum;

    stream_source_gen_if #(.DATA_WIDTH(DW)) s_if ();
    stream_source_gen_if #(.DATA_WIDTH(DW)) g_if ();

    always #5 clk = ~clk;

    stream_source_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_lfsr(cmd_lfsr), .stream_out(s_if),
        .busy(busy), .done(done), .sent_count(sent_count), .sum(sum)
    );

    stream_source_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_CYCLES(2)) dut_gap (
        .clk(clk), .reset_n(reset_n), .start(start_g), .cmd_len(cmd_len),
        .cmd_seed(cmd_seed), .cmd_lfsr(cmd_lfsr), .stream_out(g_if),
        .busy(busy_g), .done(done_g), .sent_count(sent_count_g), .sum(sum_g)
    );

    function automatic logic [DW-1:0] model_next(input logic [DW-1:0] d, input logic lfsr);
        if (!lfsr) return d + 8'd1;
        return d[0] ? ((d >> 1) ^ 8'hB8) : (d >> 1);
    endfunction

    // Scoreboard monitor: pops an expected word on every transfer and checks
    // that a stalled word stays put until it is taken.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (stall_prev) begin
            tests++;
            if (s_if.valid !== 1'b1 || s_if.data !== stall_data) begin
                fails++;
                $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                         s_if.valid, s_if.data, stall_data);
            end
        end
        if (reset_n && s_if.valid === 1'b1 && s_if.ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_word: got %h, required no transfer", s_if.data);
            end else begin
                e = exp_q.pop_front();
                if (s_if.data !== e) begin
                    fails++;
                    $display("FAIL word_data: got %h, required %h", s_if.data, e);
                end
            end
        end
        stall_prev = reset_n && (s_if.valid === 1'b1) && (s_if.ready === 1'b0);
        stall_data = s_if.data;
    end

    task automatic run_burst(input int len, input logic [DW-1:0] seed, input logic lfsr,
                             input int rmode, input bit inject, output int cycles);
        logic [DW-1:0] d;
        bit seen;
        d = (lfsr && seed == '0) ? 8'h01 : seed;
        exp_sum = '0;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(d);
            exp_sum += d;
            d = model_next(d, lfsr);
        end
        cmd_len = LW'(len); cmd_seed = seed; cmd_lfsr = lfsr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        seen = 0;
        while (!seen && cycles < 4 * len + 20) begin
            case (rmode)
                0:       s_if.ready = 1'b1;
                1:       s_if.ready = (cycles % 2 == 0);
                default: s_if.ready = 1'($urandom_range(0, 1));
            endcase
            if (inject) begin
                start = (cycles == 2);
                if (cycles == 2) begin
                    cmd_len = 16'd7; cmd_seed = 8'h99; cmd_lfsr = ~lfsr;
                end
            end
            @(negedge clk);
            if (cycles == 0) begin
                tests++;
                if (s_if.valid !== (len != 0) || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL start_latency: valid=%b busy=%b, required valid=%b busy=1",
                             s_if.valid, busy, (len != 0));
                end
            end
            if (done === 1'b1) seen = 1;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", cycles);
        end
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_width: done=%b busy=%b one cycle after done, required 0 0", done, busy);
        end
        tests++;
        if (sent_count !== LW'(len)) begin
            fails++;
            $display("FAIL sent_count: got %0d, required %0d", sent_count, len);
        end
        tests++;
        if (sum !== exp_sum) begin
            fails++;
            $display("FAIL sum: got %h, required %h", sum, exp_sum);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL words_missing: %0d words not sent, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        s_if.ready = 1'b0;
        g_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (s_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || s_if.data !== 8'h00 ||
            sent_count !== 16'd0 || sum !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h cnt=%0d sum=%h, required all 0",
                     s_if.valid, busy, done, s_if.data, sent_count, sum);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (s_if.valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", s_if.valid, busy);
        end
    endtask

    task automatic test_incr;
        int c;
        run_burst(4, 8'h10, 1'b0, 0, 1'b0, c);
        tests++;
        if (c != 5 || sum !== 8'h46) begin
            fails++;
            $display("FAIL incr_b2b: cycles=%0d sum=%h, required cycles=5 sum=46", c, sum);
        end
    endtask

    task automatic test_backpressure;
        int c;
        run_burst(3, 8'hFE, 1'b0, 1, 1'b0, c);
        tests++;
        if (c != 6 || sum !== 8'hFD) begin
            fails++;
            $display("FAIL backpressure: cycles=%0d sum=%h, required cycles=6 sum=FD", c, sum);
        end
    endtask

    task automatic test_lfsr;
        int c;
        run_burst(5, 8'h01, 1'b1, 0, 1'b1, c);
        tests++;
        if (c != 6) begin
            fails++;
            $display("FAIL lfsr_ignore_start: cycles=%0d, required 6", c);
        end
    endtask

    task automatic test_zero_len;
        s_if.ready = 1'b1;
        cmd_len = '0; cmd_seed = 8'h55; cmd_lfsr = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (s_if.valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 ||
            sent_count !== 16'd0 || sum !== 8'h00) begin
            fails++;
            $display("FAIL zero_len_done: valid=%b done=%b busy=%b cnt=%0d sum=%h, required 0 1 1 0 00",
                     s_if.valid, done, busy, sent_count, sum);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || s_if.valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_len_idle: done=%b busy=%b valid=%b, required 0 0 0", done, busy, s_if.valid);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int c;
        s_if.ready = 1'b1;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        cmd_len = 16'd6; cmd_seed = 8'h30; cmd_lfsr = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if (sent_count !== 16'd2 || s_if.valid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: cnt=%0d valid=%b, required 2 1", sent_count, s_if.valid);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if (s_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            sent_count !== 16'd0 || sum !== 8'h00) begin
            fails++;
            $display("FAIL async_reset: valid=%b busy=%b done=%b cnt=%0d sum=%h, required all 0",
                     s_if.valid, busy, done, sent_count, sum);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pre_reset_words: %0d words not sent, required 0", exp_q.size());
        end
        exp_q.delete();
        run_burst(3, 8'h40, 1'b0, 0, 1'b0, c);
    endtask

    task automatic test_back_to_back;
        int c;
        run_burst(20, 8'h00, 1'b1, 2, 1'b0, c);
        run_burst(6, 8'hFC, 1'b0, 2, 1'b0, c);
    endtask

    task automatic test_gap;
        logic ev;
        g_if.ready = 1'b1;
        cmd_len = 16'd3; cmd_seed = 8'h20; cmd_lfsr = 1'b0; start_g = 1'b1;
        @(posedge clk); #1;
        start_g = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ev = (i % 3 == 0);
            tests++;
            if (g_if.valid !== ev || done_g !== (i == 7) ||
                (ev && g_if.data !== 8'(8'h20 + i / 3))) begin
                fails++;
                $display("FAIL gap_cycle%0d: valid=%b done=%b data=%h, required valid=%b done=%b data=%h",
                         i, g_if.valid, done_g, g_if.data, ev, (i == 7), 8'(8'h20 + i / 3));
            end
            @(posedge clk); #1;
        end
        tests++;
        if (sent_count_g !== 16'd3 || sum_g !== 8'h63 || busy_g !== 1'b0) begin
            fails++;
            $display("FAIL gap_totals: cnt=%0d sum=%h busy=%b, required 3 63 0", sent_count_g, sum_g, busy_g);
        end
    endtask

    initial begin
        test_reset;
        test_incr;
        test_backpressure;
        test_lfsr;
        test_zero_len;
        test_reset_mid;
        test_back_to_back;
        test_gap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
